axi_uc_store_limiter: RTL

Sits on the CVA6 AXI master write path, between the core's AW/B port (AxiIdWidth 4) and the CCU/SoC crossbar. Classifies each write address as cached (inside the HyperRAM DRAM window) or uncached, then caps outstanding uncached writes (including ATOPs) at the core's uncached-store budget. Tracks per-ID cached/uncached order so each B response retires the correct class. AR, R and W pass through outside this block.

---
 rtl/uc_limiter_pkg.sv | 20 ++
 rtl/uc_class_fifo.sv | 53 +++++
 rtl/axi_uc_store_limiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/uc_limiter_pkg.sv
// Shared cached-region descriptor and membership test, also used by PMA checks elsewhere.
// Pure types/functions; no state, no latency.
package uc_limiter_pkg;

  localparam logic [63:0] HYAXIBase   = 64'h0000_0000_8000_0000;
  localparam logic [63:0] HYAXILength = 64'h0000_0000_4000_0000;

  typedef struct packed {
    logic [63:0] base;
    logic [63:0] length;
  } cached_region_t;

  // End of window is formed one bit wider so base + length can never wrap.
  function automatic logic in_region(input logic [63:0] addr, input cached_region_t r);
    logic [64:0] lim;
    lim = {1'b0, r.base} + {1'b0, r.length};
    return (addr >= r.base) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/uc_class_fifo.sv
// 1-bit FIFO recording the cached/uncached class of each outstanding write of one ID.
// Registered state, combinational head/full/empty; push ignored when full, pop ignored when empty.
module uc_class_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic pop_i,
  input  logic data_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Depth-1:0] mem_q, mem_d;
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;

  // Extra pointer MSB separates the full and empty cases at equal indices.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o) begin
      mem_d[wr_ptr_q[PtrW-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/axi_uc_store_limiter.sv
// Caps outstanding uncached AXI writes; zero-latency combinational AW gate, stalls AW (valid and ready low) at budget or per-ID FIFO full.
// Optional stall statistics counter built when UC_LIMITER_STATS_EN is defined.
module axi_uc_store_limiter
  import uc_limiter_pkg::*;
#(
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned MaxUncached  = 7,
  parameter int unsigned MaxPerId     = 8,
  parameter logic [63:0] CachedBase   = HYAXIBase,
  parameter logic [63:0] CachedLength = HYAXILength
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               aw_valid_i,
  output logic                               aw_ready_o,
  input  logic [AxiIdWidth-1:0]              aw_id_i,
  input  logic [AxiAddrWidth-1:0]            aw_addr_i,
  output logic                               aw_valid_o,
  input  logic                               aw_ready_i,
  input  logic                               b_valid_i,
  input  logic                               b_ready_i,
  input  logic [AxiIdWidth-1:0]              b_id_i,
  output logic [$clog2(MaxUncached+1)-1:0]   uc_cnt_o,
  output logic                               err_o,
  output logic [31:0]                        stall_cnt_o
);

  localparam int unsigned    UcW    = $clog2(MaxUncached + 1);
  localparam int unsigned    NumIds = 1 << AxiIdWidth;
  localparam cached_region_t Region = '{base: CachedBase, length: CachedLength};

  logic [NumIds-1:0] fifo_full, fifo_empty, fifo_data, fifo_push, fifo_pop;
  logic [UcW-1:0]    uc_cnt_q, uc_cnt_d;
  logic              err_q, err_d;
  logic              uc, stall, aw_hs, b_hs, pop_ok, pop_uc;

  assign uc    = !in_region(64'(aw_addr_i), Region);
  assign stall = aw_valid_i && ((uc && (uc_cnt_q == UcW'(MaxUncached))) || fifo_full[aw_id_i]);

  assign aw_valid_o = aw_valid_i && !stall;
  assign aw_ready_o = aw_ready_i && !stall;

  assign aw_hs  = aw_valid_o && aw_ready_i;
  assign b_hs   = b_valid_i && b_ready_i;
  assign pop_ok = b_hs && !fifo_empty[b_id_i];
  assign pop_uc = pop_ok && fifo_data[b_id_i];

  always_comb begin
    fifo_push = '0;
    fifo_pop  = '0;
    if (aw_hs)  fifo_push[aw_id_i] = 1'b1;
    if (pop_ok) fifo_pop[b_id_i]   = 1'b1;
  end

  // A B with nothing outstanding on its ID is flagged and otherwise ignored.
  always_comb begin
    uc_cnt_d = uc_cnt_q;
    unique case ({aw_hs && uc, pop_uc})
      2'b10:   uc_cnt_d = uc_cnt_q + 1'b1;
      2'b01:   uc_cnt_d = uc_cnt_q - 1'b1;
      default: uc_cnt_d = uc_cnt_q;
    endcase
    err_d = err_q | (b_hs && fifo_empty[b_id_i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      uc_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      uc_cnt_q <= uc_cnt_d;
      err_q    <= err_d;
    end
  end

  assign uc_cnt_o = uc_cnt_q;
  assign err_o    = err_q;

  for (genvar g = 0; g < NumIds; g++) begin : g_id
    uc_class_fifo #(
      .Depth (MaxPerId)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push[g]),
      .pop_i   (fifo_pop[g]),
      .data_i  (uc),
      .data_o  (fifo_data[g]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g])
    );
  end

`ifdef UC_LIMITER_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (aw_valid_i && stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule
